// File: rtl/fake_telescope_burst.sv
// fake_telescope_burst: burst-controlled fake antenna sample generator with valid/ready output
module fake_telescope_burst #(
  parameter int               WIDTH = 24,
  parameter int               CBITS = 16,
  parameter logic [WIDTH-1:0] CDATA = '0,
  parameter logic [WIDTH-1:0] START = '0,
  parameter logic [31:0]      SEED  = 32'h1
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [2:0]       mode_i,
  input  logic [CBITS-1:0] length_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CBITS-1:0] count_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [2:0]       mode_q;
  logic [CBITS-1:0] len_q;
  logic [31:0]      mfsr_q, mfsr_nx;
  logic [WIDTH-1:0] first, nx;
  logic [CBITS-1:0] cnt_inc;
  logic             xfer, launch;
  assign valid_o = state_q == RUN;
  assign busy_o  = state_q == RUN;
  assign done_o  = state_q == DONE;
  assign xfer    = valid_o & ready_i;
  assign launch  = state_q == IDLE && start_i && !abort_i;
  assign cnt_inc = count_o + CBITS'(1);
  assign mfsr_nx = mfsr_q[0] ? (mfsr_q >> 1) ^ 32'h80200003 : mfsr_q >> 1;
  assign first   = mode_i == 3'd1 ? SEED[WIDTH-1:0] :
                   mode_i == 3'd2 ? START :
                   mode_i == 3'd4 ? WIDTH'(1) : CDATA;
  assign nx      = mode_q == 3'd1 ? mfsr_nx[WIDTH-1:0] :
                   mode_q == 3'd2 ? data_o + WIDTH'(1) :
                   mode_q == 3'd3 ? ~data_o :
                   mode_q == 3'd4 ? (data_o << 1) | (data_o >> (WIDTH-1)) : CDATA;
  always_comb begin
    state_d = state_q;
    if (abort_i) state_d = IDLE;
    else if (state_q == IDLE) state_d = start_i ? RUN : IDLE;
    else if (state_q == DONE) state_d = IDLE;
    else if (xfer && len_q != '0 && cnt_inc == len_q) state_d = DONE;
  end
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) state_q <= IDLE;
    else state_q <= state_d;
  // a transfer coinciding with abort is still counted
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      mode_q  <= '0;
      len_q   <= '0;
      mfsr_q  <= SEED;
      data_o  <= CDATA;
      count_o <= '0;
    end else if (launch) begin
      mode_q  <= mode_i;
      len_q   <= length_i;
      mfsr_q  <= SEED;
      data_o  <= first;
      count_o <= '0;
    end else if (xfer) begin
      mfsr_q  <= mfsr_nx;
      data_o  <= nx;
      count_o <= cnt_inc;
    end
endmodule
